// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path constants used by the fetch queue and the neighbouring
// branch/redirect blocks.
package fetch_queue_pkg;

    localparam logic [31:0] IR_NOP          = 32'h0000_0000;
    localparam logic [31:0] PC_ADDR_INIT    = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_if.sv
// Decode-side handshake of the fetch queue: one {pc, instruction} entry per
// accepted valid/ready transfer.
interface fetch_queue_if #(
    parameter int XLEN = 32
);

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_ir;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_npc;

    modport master (
        output out_valid,
        output out_ir,
        output out_pc,
        output out_npc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_ir,
        input  out_pc,
        input  out_npc,
        output out_ready
    );

endinterface : fetch_queue_if

// File: rtl/fetch_queue_sync_fifo_clr.sv
// DEPTH-entry synchronous FIFO with a synchronous clear that empties it in
// one cycle; storage itself is never reset, only pointers and occupancy.
module sync_fifo_clr #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_en, push_en;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_en   = pop && (count_q != '0) && !clr;
        push_en  = push && !clr && ((count_q < CW'(DEPTH)) || pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule : sync_fifo_clr

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, reads imem combinationally and
// buffers {pc, instruction} pairs for decode; flush/redirect restart fetch.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter int              DEPTH   = 4,
    parameter logic [XLEN-1:0] PC_INIT = XLEN'(PC_ADDR_INIT),
    parameter int              PC_STEP = PC_STEP_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   flush,
    fetch_queue_if.master          dec,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   pc_q, pc_d;
    logic              pop, push, fifo_clr, fifo_empty;
    logic [2*XLEN-1:0] head;
    logic              unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // push depends on out_ready through pop, so a full queue keeps streaming.
    always_comb begin
        fifo_clr = flush || redirect_valid;
        pop      = dec.out_valid && dec.out_ready;
        push     = !fifo_clr && ((count < CW'(DEPTH)) || pop);
        pc_d     = pc_q;
        if (flush) begin
            pc_d = PC_INIT;
        end else if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= PC_INIT;
        else     pc_q <= pc_d;
    end

    assign imem_addr = pc_q;

    sync_fifo_clr #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (push),
        .pop   (pop),
        .wdata ({pc_q, imem_rdata}),
        .rdata (head),
        .empty (fifo_empty),
        .count (count)
    );

    // Empty-queue outputs are forced to fixed values rather than stale storage.
    always_comb begin
        dec.out_valid = !fifo_empty;
        dec.out_ir    = XLEN'(IR_NOP);
        dec.out_pc    = '0;
        dec.out_npc   = '0;
        if (!fifo_empty) begin
            dec.out_ir  = head[XLEN-1:0];
            dec.out_pc  = head[2*XLEN-1:XLEN];
            dec.out_npc = head[2*XLEN-1:XLEN] + XLEN'(PC_STEP);
        end
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Scenario bench for fetch_queue: a reference model pushes expected
// {pc, instruction} entries and each scenario compares the decode output.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic        redirect_valid, flush;
    logic [2:0]  count;

    ent_t        sb[$];
    logic [31:0] mpc;
    int          checks = 0;
    int          errors = 0;

    fetch_queue_if #(.XLEN(32)) dec_if ();

    fetch_queue #(
        .XLEN    (32),
        .DEPTH   (DEPTH),
        .PC_INIT (32'h0),
        .PC_STEP (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .dec            (dec_if.master),
        .count          (count)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ KEY;

    // Advance the reference model by one clock using the inputs currently driven.
    task automatic tick();
        bit   mpush;
        ent_t e;
        if (dec_if.out_ready && sb.size() > 0) void'(sb.pop_front());
        mpush = !flush && !redirect_valid && (sb.size() < DEPTH);
        if (flush) begin
            sb.delete();
            mpc = 32'h0;
        end else if (redirect_valid) begin
            sb.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else if (mpush) begin
            e.pc = mpc;
            e.ir = mpc ^ KEY;
            sb.push_back(e);
            mpc = mpc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        dec_if.out_ready = 1'b0;
        #2;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (dec_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dec_if.out_valid); end
        checks++; if (dec_if.out_ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 0", dec_if.out_ir); end
        checks++; if (dec_if.out_pc !== 32'h0 || dec_if.out_npc !== 32'h0) begin errors++; $display("FAIL reset_pc_npc: got %h/%h want 0/0", dec_if.out_pc, dec_if.out_npc); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        mpc = 32'h0;
    endtask

    task automatic test_fill();
        dec_if.out_ready = 1'b0;
        repeat (4) tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL fill_pc: got %h want 10", imem_addr); end
        checks++; if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h0) begin errors++; $display("FAIL fill_head: got v=%b pc=%h want v=1 pc=0", dec_if.out_valid, dec_if.out_pc); end
        checks++; if (dec_if.out_ir !== 32'hA5A5_0000 || dec_if.out_npc !== 32'h4) begin errors++; $display("FAIL fill_ir_npc: got %h/%h want a5a50000/4", dec_if.out_ir, dec_if.out_npc); end
        tick();
        checks++; if (count !== 3'd4 || imem_addr !== 32'h10) begin errors++; $display("FAIL fill_hold: got cnt=%0d pc=%h want 4/10", count, imem_addr); end
    endtask

    task automatic test_drain_full();
        logic [31:0] exp_pc;
        dec_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_pc = 32'(i) * 32'd4;
            checks++; if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== exp_pc) begin errors++; $display("FAIL drain_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", i, dec_if.out_valid, dec_if.out_pc, exp_pc); end
            checks++; if (dec_if.out_ir !== (exp_pc ^ KEY) || dec_if.out_npc !== exp_pc + 32'd4) begin errors++; $display("FAIL drain_ir[%0d]: got %h/%h want %h/%h", i, dec_if.out_ir, dec_if.out_npc, exp_pc ^ KEY, exp_pc + 32'd4); end
            checks++; if (count !== 3'd4) begin errors++; $display("FAIL drain_count[%0d]: got %0d want 4", i, count); end
            tick();
        end
    endtask

    task automatic test_redirect();
        dec_if.out_ready = 1'b0;
        flush = 1'b1; tick();
        flush = 1'b0; tick(); tick();
        checks++; if (count !== 3'd2 || dec_if.out_pc !== 32'h0) begin errors++; $display("FAIL redir_setup: got cnt=%0d pc=%h want 2/0", count, dec_if.out_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h203; dec_if.out_ready = 1'b1;
        checks++; if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== sb[0].pc) begin errors++; $display("FAIL redir_consume: got v=%b pc=%h want v=1 pc=%h", dec_if.out_valid, dec_if.out_pc, sb[0].pc); end
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL redir_addr: got %h want 200", imem_addr); end
        checks++; if (dec_if.out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL redir_discard: got v=%b cnt=%0d want 0/0", dec_if.out_valid, count); end
        tick();
        checks++; if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h200) begin errors++; $display("FAIL redir_target: got v=%b pc=%h want 1/200", dec_if.out_valid, dec_if.out_pc); end
        checks++; if (dec_if.out_ir !== 32'hA5A5_0200 || dec_if.out_npc !== 32'h204) begin errors++; $display("FAIL redir_ir: got %h/%h want a5a50200/204", dec_if.out_ir, dec_if.out_npc); end
    endtask

    task automatic test_flush_redirect();
        dec_if.out_ready = 1'b1;
        tick(); tick();
        flush = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick();
        flush = 1'b0; redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL flushredir_pc: got %h want 0", imem_addr); end
        checks++; if (count !== 3'd0 || dec_if.out_valid !== 1'b0) begin errors++; $display("FAIL flushredir_empty: got cnt=%0d v=%b want 0/0", count, dec_if.out_valid); end
        dec_if.out_ready = 1'b0;
        tick();
        checks++; if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h0 || count !== 3'd1) begin errors++; $display("FAIL flushredir_restart: got v=%b pc=%h cnt=%0d want 1/0/1", dec_if.out_valid, dec_if.out_pc, count); end
    endtask

    task automatic test_random_wrap();
        int          popped = 0;
        int          cyc = 0;
        logic [31:0] last = 32'hFFFF_FFFC;
        flush = 1'b1; tick();
        flush = 1'b0;
        while (popped < 4 * DEPTH && cyc < 400) begin
            dec_if.out_ready = 1'($urandom_range(0, 1));
            checks++; if (dec_if.out_valid !== (sb.size() > 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", cyc, dec_if.out_valid, sb.size() > 0); end
            checks++; if (count !== 3'(sb.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", cyc, count, sb.size()); end
            if (dec_if.out_valid && dec_if.out_ready) begin
                checks++; if (dec_if.out_pc !== last + 32'd4) begin errors++; $display("FAIL rand_seq[%0d]: got %h want %h", cyc, dec_if.out_pc, last + 32'd4); end
                checks++; if ({dec_if.out_pc, dec_if.out_ir} !== sb[0]) begin errors++; $display("FAIL rand_entry[%0d]: got %h want %h", cyc, {dec_if.out_pc, dec_if.out_ir}, sb[0]); end
                last = dec_if.out_pc;
                popped++;
            end
            tick();
            cyc++;
        end
        checks++; if (popped < 4 * DEPTH) begin errors++; $display("FAIL rand_timeout: got %0d pops want %0d", popped, 4 * DEPTH); end
    endtask

    task automatic test_async_reset();
        dec_if.out_ready = 1'b1;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dec_if.out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL arst_empty: got v=%b cnt=%0d want 0/0", dec_if.out_valid, count); end
        checks++; if (imem_addr !== 32'h0 || dec_if.out_ir !== 32'h0) begin errors++; $display("FAIL arst_regs: got addr=%h ir=%h want 0/0", imem_addr, dec_if.out_ir); end
        checks++; if (dec_if.out_pc !== 32'h0 || dec_if.out_npc !== 32'h0) begin errors++; $display("FAIL arst_pc: got %h/%h want 0/0", dec_if.out_pc, dec_if.out_npc); end
        sb.delete();
        mpc = 32'h0;
        #1;
        rst = 1'b0;
        tick();
        checks++; if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 32'h0 || imem_addr !== 32'h4) begin errors++; $display("FAIL arst_resume: got v=%b pc=%h addr=%h want 1/0/4", dec_if.out_valid, dec_if.out_pc, imem_addr); end
        tick();
        checks++; if (dec_if.out_pc !== 32'h4 || count !== 3'd1) begin errors++; $display("FAIL arst_stream: got pc=%h cnt=%0d want 4/1", dec_if.out_pc, count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_full();
        test_redirect();
        test_flush_redirect();
        test_random_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fetch_queue
